// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings and constants for the byte-serial memory controller
package mem_ctrl_pkg;
    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_e;
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
    typedef enum logic {OWN_LSB = 1'b0, OWN_IF = 1'b1} owner_e;
    localparam logic [31:0] IO_ADDR_BASE = 32'h30000;
    localparam logic [31:0] IO_MASK = 32'h30000;
    // index of the final byte of an access; the reserved size code is treated as a word
    function automatic logic [1:0] last_byte(input logic [1:0] size);
        return size == SZ_B ? 2'd0 : size == SZ_H ? 2'd1 : 2'd3;
    endfunction
endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: LSB, instruction-fetch and byte-wide RAM/IO signals of the memory controller
interface mem_ctrl_if #(parameter int ADDR_WIDTH = 32);
    logic                  _lsb_req, _lsb_r_nw, _lsb_done, _if_req, _if_done, mem_wr, io_buffer_full;
    logic [ADDR_WIDTH-1:0] _lsb_addr, _if_addr, mem_a;
    logic [1:0]            _lsb_size;
    logic [31:0]           _lsb_data, _lsb_rdata, _if_inst;
    logic [7:0]            mem_din, mem_dout;
    modport slave (
        input  _lsb_req, _lsb_r_nw, _lsb_addr, _lsb_size, _lsb_data, _if_req, _if_addr,
               mem_din, io_buffer_full,
        output _lsb_done, _lsb_rdata, _if_done, _if_inst, mem_dout, mem_a, mem_wr
    );
    modport master (
        output _lsb_req, _lsb_r_nw, _lsb_addr, _lsb_size, _lsb_data, _if_req, _if_addr,
               mem_din, io_buffer_full,
        input  _lsb_done, _lsb_rdata, _if_done, _if_inst, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_byte_seq.sv
// mem_byte_seq: issues the 1-4 byte RAM transactions of one access, rolls back on stalls
// and assembles/disassembles the little-endian word.
module mem_byte_seq #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_ADDR_BASE = ADDR_WIDTH'(mem_ctrl_pkg::IO_ADDR_BASE),
    parameter logic [ADDR_WIDTH-1:0] IO_MASK      = ADDR_WIDTH'(mem_ctrl_pkg::IO_MASK)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rdy_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  wr_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [1:0]            last_i,
    input  logic [31:0]           wdata_i,
    input  logic [7:0]            mem_din_i,
    input  logic                  io_full_i,
    output logic [ADDR_WIDTH-1:0] mem_a_o,
    output logic [7:0]            mem_dout_o,
    output logic                  mem_wr_o,
    output logic                  fin_o,
    output logic [31:0]           rword_o
);
    logic [ADDR_WIDTH-1:0] base_q, mem_a_q, mem_a_d;
    logic [31:0]           wdata_q, buf_q, buf_d;
    logic [7:0]            dout_q, dout_d;
    logic [1:0]            last_q, i_q, i_d, j_q, j_d;
    logic                  wr_q, a_vld_q, a_vld_d, pend_q, pend_d, io_stall, issue, cap;
    // a byte is issued (or written) only in a ready cycle; a read byte lands one cycle later
    assign io_stall   = ((mem_a_q & IO_MASK) == IO_ADDR_BASE) && io_full_i;
    assign issue      = a_vld_q && rdy_i && !(wr_q && io_stall);
    assign cap        = !wr_q && pend_q && rdy_i;
    assign mem_wr_o   = wr_q && issue;
    assign fin_o      = wr_q ? (mem_wr_o && i_q == last_q) : (cap && j_q == last_q);
    assign mem_a_o    = mem_a_q;
    assign mem_dout_o = dout_q;
    assign rword_o    = buf_d;
    always_comb begin
        i_d     = i_q;
        j_d     = j_q;
        a_vld_d = a_vld_q;
        pend_d  = 1'b0;
        buf_d   = buf_q;
        if (cap) begin
            buf_d[{j_q, 3'b0} +: 8] = mem_din_i;
            j_d = j_q + 2'd1;
        end
        if (issue) begin
            i_d     = i_q + 2'd1;
            a_vld_d = i_q != last_q;
            pend_d  = !wr_q;
        end
        // a stalled read drops its in-flight byte and reissues from the oldest uncaptured one
        if (!rdy_i && !wr_q && (a_vld_q || pend_q)) begin
            i_d     = j_q;
            a_vld_d = 1'b1;
        end
        if (fin_o || abort_i) a_vld_d = 1'b0;
        if (start_i) begin
            i_d     = 2'd0;
            j_d     = 2'd0;
            a_vld_d = 1'b1;
            buf_d   = '0;
        end
        mem_a_d = start_i ? addr_i : a_vld_d ? base_q + ADDR_WIDTH'(i_d) : mem_a_q;
        dout_d  = start_i ? (wr_i ? wdata_i[7:0] : 8'h00) : wdata_q[{i_d, 3'b0} +: 8];
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q  <= '0;
            mem_a_q <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            dout_q  <= '0;
            last_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            wr_q    <= 1'b0;
            a_vld_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            if (start_i) begin
                base_q  <= addr_i;
                wdata_q <= wr_i ? wdata_i : '0;
                last_q  <= last_i;
                wr_q    <= wr_i;
            end
            mem_a_q <= mem_a_d;
            buf_q   <= buf_d;
            dout_q  <= dout_d;
            i_q     <= i_d;
            j_q     <= j_d;
            a_vld_q <= a_vld_d;
            pend_q  <= pend_d;
        end
    end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates LSB and fetch requests onto the byte-wide RAM/IO port,
// handling flushes and producing the one-cycle done pulses.
module mem_ctrl #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_ADDR_BASE = ADDR_WIDTH'(mem_ctrl_pkg::IO_ADDR_BASE)
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    input  logic      _clear,
    mem_ctrl_if.slave bus
);
    import mem_ctrl_pkg::*;
    state_e      state_q;
    owner_e      own_q;
    logic        lsb_done_q, if_done_q, start, abort, fin;
    logic [31:0] lsb_rdata_q, if_inst_q, rword;
    // the LSB wins arbitration; a flush in IDLE suppresses sampling
    assign start = state_q == IDLE && rdy_in && !_clear && (bus._lsb_req || bus._if_req);
    assign abort = state_q == READ && _clear;
    assign bus._lsb_done  = lsb_done_q;
    assign bus._lsb_rdata = lsb_rdata_q;
    assign bus._if_done   = if_done_q;
    assign bus._if_inst   = if_inst_q;
    mem_byte_seq #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .IO_ADDR_BASE(IO_ADDR_BASE)
    ) u_seq (
        .clk_i     (clk_in),
        .rst_ni    (rst_in),
        .rdy_i     (rdy_in),
        .start_i   (start),
        .abort_i   (abort),
        .wr_i      (bus._lsb_req && !bus._lsb_r_nw),
        .addr_i    (bus._lsb_req ? bus._lsb_addr : bus._if_addr),
        .last_i    (bus._lsb_req ? last_byte(bus._lsb_size) : 2'd3),
        .wdata_i   (bus._lsb_data),
        .mem_din_i (bus.mem_din),
        .io_full_i (bus.io_buffer_full),
        .mem_a_o   (bus.mem_a),
        .mem_dout_o(bus.mem_dout),
        .mem_wr_o  (bus.mem_wr),
        .fin_o     (fin),
        .rword_o   (rword)
    );
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            own_q       <= OWN_LSB;
            lsb_done_q  <= 1'b0;
            if_done_q   <= 1'b0;
            lsb_rdata_q <= '0;
            if_inst_q   <= '0;
        end else begin
            lsb_done_q <= 1'b0;
            if_done_q  <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= bus._lsb_req && !bus._lsb_r_nw ? WRITE : READ;
                    own_q   <= bus._lsb_req ? OWN_LSB : OWN_IF;
                end
                READ: if (_clear) state_q <= IDLE;
                else if (fin) begin
                    state_q <= DONE;
                    if (own_q == OWN_LSB) begin
                        lsb_done_q  <= 1'b1;
                        lsb_rdata_q <= rword;
                    end else begin
                        if_done_q <= 1'b1;
                        if_inst_q <= rword;
                    end
                end
                // stores are committed once started, so a flush does not cut them short
                WRITE: if (fin) begin
                    state_q    <= DONE;
                    lsb_done_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed cycle-accurate checks of mem_ctrl against hand-computed expectations
module tb_mem_ctrl;
    logic clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, _clear = 1'b0;
    int vec = 0, miss = 0;
    logic [7:0] t4b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    mem_ctrl_if bus ();
    mem_ctrl dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        ._clear(_clear),
        .bus   (bus)
    );
    always #5 clk_in = ~clk_in;
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        case (a)
            32'h100: return 8'h11;
            32'h101: return 8'h22;
            32'h102: return 8'h33;
            32'h103: return 8'h44;
            default: return a[7:0] + 8'h40;
        endcase
    endfunction
    always @(posedge clk_in) bus.mem_din <= ram_rd(bus.mem_a);
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_mem_wr"}, 32'(bus.mem_wr), 32'd0);
        chk({tag, "_mem_a"}, bus.mem_a, 32'd0);
        chk({tag, "_mem_dout"}, 32'(bus.mem_dout), 32'd0);
        chk({tag, "_dones"}, {30'd0, bus._lsb_done, bus._if_done}, 32'd0);
        chk({tag, "_rdata"}, bus._lsb_rdata, 32'd0);
        chk({tag, "_inst"}, bus._if_inst, 32'd0);
    endtask
    initial begin
        bus._lsb_req = 0; bus._lsb_r_nw = 0; bus._lsb_addr = 0; bus._lsb_size = 0;
        bus._lsb_data = 0; bus._if_req = 0; bus._if_addr = 0; bus.io_buffer_full = 0;
        repeat (2) @(posedge clk_in);
        #1;
        chk_zero("reset");
        rst_in = 1;
        // 1: word load at 0x100
        tick();
        bus._lsb_req = 1; bus._lsb_r_nw = 1; bus._lsb_addr = 32'h100; bus._lsb_size = 2'd2;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k <= 4) chk("t1_mem_a", bus.mem_a, 32'h100 + 32'(k) - 32'd1);
            chk("t1_done", 32'(bus._lsb_done), 32'(k == 6));
        end
        chk("t1_rdata", bus._lsb_rdata, 32'h44332211);
        bus._lsb_req = 0;
        // 2: byte store 0xAB to 0x200
        tick();
        bus._lsb_req = 1; bus._lsb_r_nw = 0; bus._lsb_addr = 32'h200; bus._lsb_size = 2'd0;
        bus._lsb_data = 32'h0000_00AB;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("t2_mem_wr", 32'(bus.mem_wr), 32'(k == 1));
            if (k == 1) chk("t2_mem_a", bus.mem_a, 32'h200);
            if (k == 1) chk("t2_mem_dout", 32'(bus.mem_dout), 32'hAB);
            chk("t2_done", 32'(bus._lsb_done), 32'(k == 2));
            if (k == 2) bus._lsb_req = 0;
        end
        // 3: simultaneous fetch at 0x0 and half load at 0x10; LSB first
        bus._if_req = 1; bus._if_addr = 32'h0;
        bus._lsb_req = 1; bus._lsb_r_nw = 1; bus._lsb_addr = 32'h10; bus._lsb_size = 2'd1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            chk("t3_lsb_done", 32'(bus._lsb_done), 32'(k == 4));
            chk("t3_if_done", 32'(bus._if_done), 32'(k == 11));
            if (k == 4) begin
                chk("t3_rdata", bus._lsb_rdata, 32'h0000_5150);
                bus._lsb_req = 0;
            end
        end
        chk("t3_inst", bus._if_inst, 32'h4342_4140);
        bus._if_req = 0;
        // 4: fetch flushed in cycle 3, word store raised during the flush
        tick();
        bus._if_req = 1; bus._if_addr = 32'h40;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 3) begin
                _clear = 1; bus._if_req = 0;
                bus._lsb_req = 1; bus._lsb_r_nw = 0; bus._lsb_addr = 32'h44;
                bus._lsb_size = 2'd2; bus._lsb_data = 32'hDEAD_BEEF;
            end
            if (k == 4) _clear = 0;
            #1;
            chk("t4_if_done", 32'(bus._if_done), 32'd0);
            chk("t4_lsb_done", 32'(bus._lsb_done), 32'(k == 9));
            chk("t4_mem_wr", 32'(bus.mem_wr), 32'(k >= 5 && k <= 8));
            if (k >= 5 && k <= 8) begin
                chk("t4_mem_a", bus.mem_a, 32'h44 + 32'(k - 5));
                chk("t4_mem_dout", 32'(bus.mem_dout), 32'(t4b[k-5]));
            end
            if (k == 9) bus._lsb_req = 0;
        end
        // 5: IO byte store with io_buffer_full high for three cycles
        tick();
        bus._lsb_req = 1; bus._lsb_r_nw = 0; bus._lsb_addr = 32'h30000; bus._lsb_size = 2'd0;
        bus._lsb_data = 32'h0000_005A;
        for (int k = 1; k <= 5; k++) begin
            tick();
            bus.io_buffer_full = k <= 3;
            #1;
            chk("t5_mem_wr", 32'(bus.mem_wr), 32'(k == 4));
            if (k == 4) chk("t5_mem_a", bus.mem_a, 32'h30000);
            if (k == 4) chk("t5_mem_dout", 32'(bus.mem_dout), 32'h5A);
            chk("t5_done", 32'(bus._lsb_done), 32'(k == 5));
        end
        bus._lsb_req = 0;
        // 6a: word load at 0x20 with rdy_in low in cycles 3 and 4
        tick();
        bus._lsb_req = 1; bus._lsb_r_nw = 1; bus._lsb_addr = 32'h20; bus._lsb_size = 2'd2;
        for (int k = 1; k <= 9; k++) begin
            tick();
            rdy_in = !(k == 3 || k == 4);
            #1;
            chk("t6_done", 32'(bus._lsb_done), 32'(k == 9));
            chk("t6_mem_wr", 32'(bus.mem_wr), 32'd0);
            if (k == 4 || k == 5) chk("t6_rollback_a", bus.mem_a, 32'h21);
        end
        chk("t6_rdata", bus._lsb_rdata, 32'h6362_6160);
        bus._lsb_req = 0;
        // 6b: reset asserted in cycle 4 of a load
        tick();
        bus._lsb_req = 1; bus._lsb_addr = 32'h100;
        repeat (4) tick();
        rst_in = 0;
        #1;
        chk_zero("t6_rst");
        bus._lsb_req = 0;
        tick();
        rst_in = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t6_no_done", {30'd0, bus._lsb_done, bus._if_done}, 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
